// File: rtl/semeion_frame_loader_pkg.sv
// Shared constants, FSM state type and the digit/label-bit mapping for the
// Semeion frame loader.
package semeion_pkg;

   localparam int INPUT_SIZE   = 256;
   localparam int LABEL_SIZE   = 10;
   localparam int BYTE_COUNT   = 34;
   localparam int RECORD_WIDTH = INPUT_SIZE + LABEL_SIZE;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   // Digit d is flagged by label bit [LABEL_SIZE-1-d] (digit 0 is the label MSB).
   function automatic logic [3:0] label_bit(input logic [3:0] digit);
      return 4'(LABEL_SIZE - 1) - digit;
   endfunction

endpackage

// File: rtl/semeion_frame_loader_if.sv
// Byte-stream, classifier and scoring signals of the frame loader.
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready.
interface semeion_frame_loader_if #(
   parameter int INPUT_SIZE  = semeion_pkg::INPUT_SIZE,
   parameter int COUNT_WIDTH = 16
);
   import semeion_pkg::*;

   logic [7:0]             byte_data;
   logic                   byte_valid;
   logic                   byte_ready;
   logic [INPUT_SIZE-1:0]  layer_1_input;
   logic                   load;
   logic                   done;
   logic [3:0]             max;
   logic                   result_valid;
   logic [3:0]             predicted;
   logic [3:0]             expected;
   logic                   correct;
   logic                   label_err;
   logic                   timeout_err;
   logic [COUNT_WIDTH-1:0] total_count;
   logic [COUNT_WIDTH-1:0] correct_count;
   state_t                 state_dbg;

   modport master (
      output byte_data, byte_valid, done, max,
      input  byte_ready, layer_1_input, load, result_valid, predicted,
             expected, correct, label_err, timeout_err, total_count,
             correct_count, state_dbg
   );

   modport slave (
      input  byte_data, byte_valid, done, max,
      output byte_ready, layer_1_input, load, result_valid, predicted,
             expected, correct, label_err, timeout_err, total_count,
             correct_count, state_dbg
   );

endinterface

// File: rtl/semeion_frame_loader_label_decoder.sv
// One-hot label to digit index; legal only when exactly one bit is set,
// otherwise the index is forced to zero.
module label_decoder
   import semeion_pkg::*;
(
   input  logic [LABEL_SIZE-1:0] label,
   output logic [3:0]            index,
   output logic                  legal
);

   logic [3:0] hits;

   always_comb begin
      hits  = '0;
      index = '0;
      for (int d = 0; d < LABEL_SIZE; d++) begin
         if (label[label_bit(4'(d))]) begin
            hits  = hits + 4'd1;
            index = 4'(d);
         end
      end
      legal = (hits == 4'd1);
      if (!legal) index = '0;
   end

endmodule

// File: rtl/semeion_frame_loader.sv
// Assembles a 34-byte record, launches layer 1 with a one-cycle load pulse,
// then scores the classifier answer against the record label.
module semeion_frame_loader #(
   parameter int INPUT_SIZE     = semeion_pkg::INPUT_SIZE,
   parameter int LABEL_SIZE     = semeion_pkg::LABEL_SIZE,
   parameter int BYTE_COUNT     = semeion_pkg::BYTE_COUNT,
   parameter int TIMEOUT_CYCLES = 2048,
   parameter int COUNT_WIDTH    = 16
) (
   input logic                   clk,
   input logic                   reset,
   semeion_frame_loader_if.slave bus
);
   import semeion_pkg::*;

   localparam int SHREG_W = BYTE_COUNT * 8;
   localparam int PAD     = SHREG_W - (INPUT_SIZE + LABEL_SIZE);
   localparam int BCNT_W  = $clog2(BYTE_COUNT);
   localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_t                 state_q, state_d;
   logic [SHREG_W-1:0]     shreg_q, shreg_d;
   logic [BCNT_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                   done_prev_q;
   logic [INPUT_SIZE-1:0]  layer_1_input_q, layer_1_input_d;
   logic [3:0]             predicted_q, predicted_d;
   logic [3:0]             expected_q, expected_d;
   logic                   correct_q, correct_d;
   logic                   label_err_q, label_err_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [COUNT_WIDTH-1:0] total_q, total_d;
   logic [COUNT_WIDTH-1:0] correct_cnt_q, correct_cnt_d;
   logic                   byte_ready, load, result_valid;
   logic [3:0]             label_index;
   logic                   label_legal;
   logic                   unused_shreg_top;

   // The oldest byte is only ever consumed through shreg_d on the final shift.
   assign unused_shreg_top = ^shreg_q[SHREG_W-1 -: 8];

   label_decoder u_label_decoder (
      .label (shreg_q[PAD +: LABEL_SIZE]),
      .index (label_index),
      .legal (label_legal)
   );

   always_comb begin
      state_d         = state_q;
      shreg_d         = shreg_q;
      byte_cnt_d      = byte_cnt_q;
      wait_cnt_d      = wait_cnt_q;
      layer_1_input_d = layer_1_input_q;
      predicted_d     = predicted_q;
      expected_d      = expected_q;
      correct_d       = correct_q;
      label_err_d     = label_err_q;
      timeout_err_d   = timeout_err_q;
      total_d         = total_q;
      correct_cnt_d   = correct_cnt_q;
      byte_ready      = 1'b0;
      load            = 1'b0;
      result_valid    = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            byte_ready = 1'b1;
            if (bus.byte_valid) begin
               shreg_d = {shreg_q[SHREG_W-9:0], bus.byte_data};
               if (byte_cnt_q == BCNT_W'(BYTE_COUNT - 1)) begin
                  byte_cnt_d      = '0;
                  layer_1_input_d = shreg_d[SHREG_W-1 -: INPUT_SIZE];
                  state_d         = ST_LOAD;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               end
            end
         end
         ST_LOAD: begin
            load       = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion edge seen on the timeout cycle still counts.
            if (bus.done && !done_prev_q) begin
               predicted_d = bus.max;
               expected_d  = label_index;
               label_err_d = !label_legal;
               correct_d   = label_legal && (bus.max == label_index);
               state_d     = ST_REPORT;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES)) begin
               timeout_err_d = 1'b1;
               state_d       = ST_FILL;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_REPORT: begin
            result_valid = 1'b1;
            if (total_q != '1) total_d = total_q + COUNT_WIDTH'(1);
            if (correct_q && (correct_cnt_q != '1)) correct_cnt_d = correct_cnt_q + COUNT_WIDTH'(1);
            state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_FILL;
         shreg_q         <= '0;
         byte_cnt_q      <= '0;
         wait_cnt_q      <= '0;
         done_prev_q     <= 1'b0;
         layer_1_input_q <= '0;
         predicted_q     <= '0;
         expected_q      <= '0;
         correct_q       <= 1'b0;
         label_err_q     <= 1'b0;
         timeout_err_q   <= 1'b0;
         total_q         <= '0;
         correct_cnt_q   <= '0;
      end else begin
         state_q         <= state_d;
         shreg_q         <= shreg_d;
         byte_cnt_q      <= byte_cnt_d;
         wait_cnt_q      <= wait_cnt_d;
         done_prev_q     <= bus.done;
         layer_1_input_q <= layer_1_input_d;
         predicted_q     <= predicted_d;
         expected_q      <= expected_d;
         correct_q       <= correct_d;
         label_err_q     <= label_err_d;
         timeout_err_q   <= timeout_err_d;
         total_q         <= total_d;
         correct_cnt_q   <= correct_cnt_d;
      end
   end

   assign bus.byte_ready    = byte_ready;
   assign bus.load          = load;
   assign bus.result_valid  = result_valid;
   assign bus.layer_1_input = layer_1_input_q;
   assign bus.predicted     = predicted_q;
   assign bus.expected      = expected_q;
   assign bus.correct       = correct_q;
   assign bus.label_err     = label_err_q;
   assign bus.timeout_err   = timeout_err_q;
   assign bus.total_count   = total_q;
   assign bus.correct_count = correct_cnt_q;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_semeion_frame_loader.sv
// Directed bench for semeion_frame_loader: record-level model with a
// per-cycle compare process plus hand-computed literal checks.
module tb_semeion_frame_loader;
   import semeion_pkg::*;

   typedef struct packed {
      logic [3:0] pred;
      logic [3:0] digit;
      logic       corr;
      logic       lerr;
   } res_t;

   logic clk;
   logic reset;

   semeion_frame_loader_if #(.INPUT_SIZE(256), .COUNT_WIDTH(16)) bus ();

   semeion_frame_loader #(
      .INPUT_SIZE(256), .LABEL_SIZE(10), .BYTE_COUNT(34),
      .TIMEOUT_CYCLES(2048), .COUNT_WIDTH(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int load_cnt = 0;
   int handled  = 0;
   bit chk_en   = 0;

   logic [255:0] exp_img_q[$];
   logic [9:0]   exp_res_q[$];
   logic [255:0] last_img;
   res_t         last_res;
   int           model_total;
   int           model_corr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit reached, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Scoring rules: exactly one label bit set means digit 9-position; anything else is illegal.
   function automatic res_t model_score(input logic [9:0] lab, input logic [3:0] m);
      res_t r;
      r.pred  = m;
      r.digit = 4'd0;
      r.lerr  = ($countones(lab) != 1);
      if (!r.lerr)
         for (int d = 0; d < 10; d++)
            if (lab == (10'b1 << (9 - d))) r.digit = 4'(d);
      r.corr = !r.lerr && (m == r.digit);
      return r;
   endfunction

   // Compare process: runs 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         if (bus.load) begin
            load_cnt++;
            if (exp_img_q.size() == 0) check("unexpected_load", 1'b1, 1'b0);
            else last_img = exp_img_q.pop_front();
         end
         check("layer_1_input", bus.layer_1_input, last_img);
         if (bus.result_valid) begin
            if (exp_res_q.size() == 0) check("unexpected_result_valid", 1'b1, 1'b0);
            else last_res = exp_res_q.pop_front();
         end
         check("predicted", bus.predicted, last_res.pred);
         check("expected", bus.expected, last_res.digit);
         check("correct", bus.correct, last_res.corr);
         check("label_err", bus.label_err, last_res.lerr);
         check("total_count", bus.total_count, model_total);
         check("correct_count", bus.correct_count, model_corr);
         if (bus.result_valid) begin
            model_total++;
            if (last_res.corr) model_corr++;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      chk_en         = 0;
      bus.byte_valid = 1'b0;
      bus.done       = 1'b0;
      reset          = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_img_q.delete();
      exp_res_q.delete();
      model_total = 0;
      model_corr  = 0;
      last_img    = '0;
      last_res    = '0;
      chk_en      = 1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.byte_data  = b;
      bus.byte_valid = 1'b1;
      for (int t = 0; t < 5000; t++) begin
         if (bus.byte_ready) begin
            @(posedge clk);
            return;
         end
         @(negedge clk);
      end
      check("byte_accept_timeout", 1'b1, 1'b0);
   endtask

   task automatic send_record(input logic [7:0] img, input logic [9:0] lab,
                              input logic [5:0] pad, input bit expect_load);
      logic [271:0] rec;
      rec = {{32{img}}, lab, pad};
      if (expect_load) exp_img_q.push_back(rec[271:16]);
      for (int i = 0; i < 34; i++) send_byte(rec[271 - 8 * i -: 8]);
      if (expect_load) begin
         #1;
         check("load_after_last_byte", bus.load, 1'b1);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_load(output bit ok);
      ok = 0;
      for (int t = 0; t < 5000; t++) begin
         if (load_cnt > handled) begin
            handled++;
            ok = 1;
            return;
         end
         @(negedge clk);
      end
      check("load_wait_timeout", 1'b1, 1'b0);
   endtask

   task automatic respond(input int delay, input logic [9:0] lab, input logic [3:0] m);
      bit ok;
      wait_load(ok);
      if (ok) begin
         exp_res_q.push_back(model_score(lab, m));
         repeat (delay) @(negedge clk);
         bus.max  = m;
         bus.done = 1'b1;
         @(posedge clk);
         #1;
         check("result_valid_latency", bus.result_valid, 1'b1);
         @(posedge clk);
         #1;
         check("byte_ready_after_report", bus.byte_ready, 1'b1);
         @(negedge clk);
         bus.done = 1'b0;
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit ok;
      int cnt;
      reset          = 1'b1;
      bus.byte_data  = '0;
      bus.byte_valid = 1'b0;
      bus.done       = 1'b0;
      bus.max        = '0;
      do_reset();
      @(negedge clk);
      check("rst_byte_ready", bus.byte_ready, 1'b1);
      check("rst_load", bus.load, 1'b0);
      check("rst_result_valid", bus.result_valid, 1'b0);
      check("rst_timeout_err", bus.timeout_err, 1'b0);
      check("rst_state", bus.state_dbg, ST_FILL);

      // Image 0xA5, digit 4 (label bit 5), classifier answers 4
      send_record(8'hA5, 10'h020, 6'h00, 1);
      respond(300, 10'h020, 4'd4);
      settle();
      check("t1_image", bus.layer_1_input, {32{8'hA5}});
      check("t1_predicted", bus.predicted, 4'd4);
      check("t1_expected", bus.expected, 4'd4);
      check("t1_correct", bus.correct, 1'b1);
      check("t1_total", bus.total_count, 16'd1);
      check("t1_correct_count", bus.correct_count, 16'd1);

      do_reset();
      send_record(8'hA5, 10'h020, 6'h00, 1);
      respond(300, 10'h020, 4'd7);
      settle();
      check("t2_correct", bus.correct, 1'b0);
      check("t2_total", bus.total_count, 16'd1);
      check("t2_correct_count", bus.correct_count, 16'd0);

      // Illegal labels: none set, then two set
      send_record(8'h11, 10'h000, 6'h00, 1);
      respond(40, 10'h000, 4'd0);
      settle();
      check("t3a_label_err", bus.label_err, 1'b1);
      check("t3a_correct", bus.correct, 1'b0);
      send_record(8'h22, 10'h300, 6'h00, 1);
      respond(40, 10'h300, 4'd0);
      settle();
      check("t3b_label_err", bus.label_err, 1'b1);
      check("t3b_expected", bus.expected, 4'd0);
      check("t3b_total", bus.total_count, 16'd3);

      // Classifier never completes
      send_record(8'h5A, 10'h020, 6'h00, 1);
      wait_load(ok);
      check("t4_timeout_before", bus.timeout_err, 1'b0);
      cnt = 0;
      while (!bus.byte_ready && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      check("t4_ready_latency", cnt, 2050);
      check("t4_timeout_err", bus.timeout_err, 1'b1);
      check("t4_total", bus.total_count, 16'd3);
      send_record(8'h5A, 10'h020, 6'h00, 1);
      respond(10, 10'h020, 4'd4);
      settle();
      check("t4_timeout_sticky", bus.timeout_err, 1'b1);
      check("t4_total_after", bus.total_count, 16'd4);
      check("t4_correct_after", bus.correct_count, 16'd1);

      // Reset mid-record, then digit 9 (label bit 0) with nonzero pad bits
      for (int i = 0; i < 20; i++) send_byte(8'hFF);
      do_reset();
      @(negedge clk);
      check("t5_timeout_cleared", bus.timeout_err, 1'b0);
      send_record(8'h3C, 10'h001, 6'h15, 1);
      respond(5, 10'h001, 4'd9);
      settle();
      check("t5_image", bus.layer_1_input, {32{8'h3C}});
      check("t5_expected", bus.expected, 4'd9);
      check("t5_correct", bus.correct, 1'b1);
      check("t5_load_count", load_cnt, handled);

      // done toggling during FILL; next record's bytes held valid through WAIT
      fork
         begin
            repeat (5) begin
               @(negedge clk);
               bus.done = 1'b1;
               @(negedge clk);
               bus.done = 1'b0;
            end
         end
         send_record(8'h81, 10'h200, 6'h00, 1);
      join
      fork
         respond(50, 10'h200, 4'd0);
         send_record(8'hE7, 10'h002, 6'h00, 1);
      join
      respond(20, 10'h002, 4'd3);
      settle();
      check("t6_image", bus.layer_1_input, {32{8'hE7}});
      check("t6_expected", bus.expected, 4'd8);
      check("t6_predicted", bus.predicted, 4'd3);
      check("t6_total", bus.total_count, 16'd3);
      check("t6_correct_count", bus.correct_count, 16'd2);

      check("img_queue_drained", exp_img_q.size(), 0);
      check("res_queue_drained", exp_res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/semeion_frame_loader.md
# semeion_frame_loader

Upstream input stage for the Semeion digit classifier. Accepts a serialized 266-bit image record (256 pixel bits plus a 10-bit one-hot label) as a byte stream, assembles it, and presents the 256-bit image to `layer_1_complete` with a single-cycle `load` pulse. It then waits for `max_of_10` to finish and scores the predicted digit against the record's label, keeping running totals.

## Interface
Parameters:
- `INPUT_SIZE`, 256, image bits driven to layer 1.
- `LABEL_SIZE`, 10, one-hot label bits per record.
- `BYTE_COUNT`, 34, bytes per record (272 bits; low 6 pad bits ignored).
- `TIMEOUT_CYCLES`, 2048, maximum wait for classifier completion.
- `COUNT_WIDTH`, 16, width of the scoring counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `byte_data`  in  8  record byte, MSB-first stream.
- `byte_valid`  in  1  `byte_data` valid.
- `byte_ready`  out  1  loader can accept a byte.
- `layer_1_input`  out  INPUT_SIZE  image to layer 1.
- `load`  out  1  one-cycle start pulse to layer 1.
- `done`  in  1  completion from `max_of_10`.
- `max`  in  4  predicted digit from `max_of_10`.
- `result_valid`  out  1  one-cycle scoring strobe.
- `predicted`  out  4  captured `max`.
- `expected`  out  4  digit decoded from the label.
- `correct`  out  1  predicted == expected and label legal.
- `label_err`  out  1  label not exactly one-hot.
- `timeout_err`  out  1  sticky; classifier did not finish in time.
- `total_count`  out  COUNT_WIDTH  records scored.
- `correct_count`  out  COUNT_WIDTH  records scored correct.

## Operation
- **States:** FILL, LOAD, WAIT, REPORT.
- **FILL**
  - `byte_ready`=1; a byte is accepted when `byte_valid`&&`byte_ready`.
  - Each accepted byte shifts into the 272-bit shift register from the LSB end, so the first byte lands in bits [271:264].
  - The byte counter runs 0..33; the 34th accepted byte moves the FSM to LOAD.
  - Record is `shreg[271:6]`: image = record[265:10], label = record[9:0].
- **LOAD**
  - `layer_1_input` is registered from record[265:10].
  - `load`=1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - `byte_ready`=0.
  - On a rising edge of `done` (registered previous value), capture `max` into `predicted` and go to REPORT.
  - If the wait counter reaches TIMEOUT_CYCLES first: set `timeout_err`, score nothing, go to FILL.
- **REPORT**
  - `result_valid`=1 for one cycle.
  - `total_count` += 1; `correct_count` += `correct`.
  - Go to FILL.
- **Label mapping:** digit d corresponds to label bit [9-d]. `expected` = d. With zero or more than one bit set, `label_err`=1, `expected`=0, `correct`=0.
- **Counters:** both saturate at all-ones and never wrap.
- **Output holding:**
  - `layer_1_input` holds its value until the next LOAD.
  - `predicted`, `expected`, `correct` and `label_err` hold until the next REPORT.
- **Ignored inputs:**
  - `done` edges outside WAIT are ignored.
  - `byte_valid` outside FILL is ignored; no byte is consumed.
- **Reset**
  - All outputs and state go to zero, and the FSM goes to FILL.
  - Reset mid-frame or mid-WAIT discards the partial record and the pending result.
  - `timeout_err` clears only on reset.

## Timing
- Byte accepted at cycle N is visible in the shift register at N+1.
- 34th byte accepted at cycle N: FSM is in LOAD during N+1. `load` and the new `layer_1_input` are valid together in that cycle.
- `done` rises at cycle M (sampled while in WAIT): edge detected at M, `result_valid` high at M+1, counters updated at M+2.
- Minimum record-to-record time is 34 + 1 + classifier latency + 1 cycles.
- `byte_ready` returns high the cycle after REPORT or timeout.
- Timeout fires when the wait count equals TIMEOUT_CYCLES. The count starts at 0 on the first WAIT cycle.

## Structure
- Package `semeion_pkg` holds:
  - INPUT_SIZE, LABEL_SIZE, BYTE_COUNT and record width 266.
  - The FSM state enum.
  - The digit-to-label-bit mapping function.
- Sub-module `label_decoder`: combinational 10-bit one-hot to 4-bit index plus a `legal` flag. Instantiated once.

## Test plan
- Reset, then stream 34 bytes encoding image 0xA5 repeated with label digit 4 (bit 5 set); drive `done` rise 300 cycles after `load` with `max`=4 -> one `load` pulse with correct image; `result_valid`, `predicted`=4, `expected`=4, `correct`=1, counts 1/1.
- Same record but `max`=7 -> `correct`=0, `total_count`=1, `correct_count`=0.
- Label 0x000, then label 0x300 -> `label_err`=1 and `correct`=0 for both, even when `max` matches 0.
- Withhold `done` -> `timeout_err`=1 after 2048 WAIT cycles, no `result_valid`, `byte_ready` back to 1, counts unchanged.
- Assert `reset` after 20 bytes, then send a full record -> only one `load`, image taken from the post-reset bytes only.
- Toggle `done` during FILL and hold `byte_valid` during WAIT -> no spurious result, no byte lost.
